// File: rtl/array_alu_axi4_master.sv
// Single-outstanding AXI4 initiator: turns one command into one AXI4 write
// (AW+W+B) or one read (AR+R), then offers the slave's response. The ID
// returned on R is compared against the ID that was issued on AR.
module array_alu_axi4_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              areset,
    // command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [ID_W-1:0]   cmd_id,
    // response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic [ID_W-1:0]   rsp_id,
    output logic              rsp_id_err,
    // AXI4 write address / data / response
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    input  logic              bvalid,
    input  logic [1:0]        bresp,
    output logic              bready,
    // AXI4 read address / data
    output logic              arvalid,
    input  logic              arready,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_RESP = 3'd4;
    localparam logic [2:0] RSP     = 3'd5;

    logic [2:0] state;

    // AW and W each complete when their valid is already gone or handshakes now
    logic aw_done;
    logic w_done;
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid  || wready;

    // Transaction sequencer; every output is a register so nothing glitches
    // toward the slave and reset forces all of them low at once.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            awvalid    <= 1'b0;
            awaddr     <= '0;
            wvalid     <= 1'b0;
            wdata      <= '0;
            bready     <= 1'b0;
            arvalid    <= 1'b0;
            arid       <= '0;
            araddr     <= '0;
            rready     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_resp   <= 2'b00;
            rsp_id     <= '0;
            rsp_id_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // cmd_ready rises one cycle after reset release or after
                    // the previous response was consumed
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            state   <= WR_REQ;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            awaddr  <= cmd_addr;
                            wdata   <= cmd_wdata;
                        end else begin
                            state   <= RD_REQ;
                            arvalid <= 1'b1;
                            araddr  <= cmd_addr;
                            arid    <= cmd_id;
                        end
                    end
                end
                WR_REQ: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        state  <= WR_RESP;
                        bready <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (bvalid && bready) begin
                        bready     <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_write  <= 1'b1;
                        rsp_rdata  <= '0;
                        rsp_resp   <= bresp;
                        rsp_id     <= '0;
                        rsp_id_err <= 1'b0;
                        state      <= RSP;
                    end
                end
                RD_REQ: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (rvalid && rready) begin
                        rready     <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_write  <= 1'b0;
                        rsp_rdata  <= rdata;
                        rsp_resp   <= rresp;
                        rsp_id     <= rid;
                        rsp_id_err <= (rid != arid);
                        state      <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array_alu_axi4_master.sv
// Bench for array_alu_axi4_master: a behavioural AXI slave with per-transaction
// ready/response delays, and a single compare process that checks handshake
// protocol and response contents every cycle against expectations derived
// from the issued command and the slave's own response choices.
module tb_array_alu_axi4_master;

    logic        clk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_id;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  rsp_id;
    logic        rsp_id_err;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic        arvalid, arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic        rvalid, rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    always #5 clk = ~clk;

    array_alu_axi4_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk(clk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_id(cmd_id),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_id(rsp_id),
        .rsp_id_err(rsp_id_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp)
    );

    int n_chk = 0;
    int n_fail = 0;

    // expectation for the transaction in flight, written by the stimulus
    logic        chk_en = 1'b0;
    logic        exp_write;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_cid, exp_id;
    logic [1:0]  exp_resp;
    logic        exp_err;
    // hand-computed literal response for directed transactions
    logic        lit_en = 1'b0;
    logic        lit_write;
    logic [31:0] lit_rdata;
    logic [1:0]  lit_resp;
    logic [3:0]  lit_id;
    logic        lit_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // compare-process state
    bit          busy, just_acc;
    logic [7:0]  aw_n, w_n, ar_n, b_n, r_n;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_br, p_bv, p_rr, p_rv;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_arid;

    // compare process: outputs sampled on the falling edge, handshakes seen
    // here complete on the following rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (areset || !chk_en) begin
                if (areset) begin
                    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
                    chk("reset_handshakes", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
                    chk("reset_addr", {awaddr, araddr}, 64'd0);
                    chk("reset_data", {wdata, rsp_rdata}, 64'd0);
                    chk("reset_rsp", 64'({rsp_write, rsp_resp, rsp_id, rsp_id_err, arid}), 64'd0);
                end
                busy = 0; just_acc = 0;
                aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
                {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_br, p_bv, p_rr, p_rv} = '0;
                p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_arid = 0;
            end else begin
                chk("cmd_ready", 64'(cmd_ready), 64'(!busy));
                if (!busy)
                    chk("idle_outputs", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
                if (just_acc)
                    chk("cmd_to_valid", 64'({awvalid, wvalid, arvalid}), exp_write ? 64'd6 : 64'd1);
                if (p_awv && !p_awr) chk("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, p_awaddr}));
                if (p_wv && !p_wr)   chk("w_hold", 64'({wvalid, wdata}), 64'({1'b1, p_wdata}));
                if (p_arv && !p_arr) chk("ar_hold", 64'({arvalid, arid, araddr}), 64'({1'b1, p_arid, p_araddr}));
                if (p_br && !p_bv)   chk("bready_hold", 64'(bready), 64'd1);
                if (p_rr && !p_rv)   chk("rready_hold", 64'(rready), 64'd1);
                if (awvalid) chk("awaddr", 64'(awaddr), 64'(exp_addr));
                if (wvalid)  chk("wdata", 64'(wdata), 64'(exp_wdata));
                if (arvalid) chk("ar_fields", 64'({arid, araddr}), 64'({exp_cid, exp_addr}));
                if (bready)
                    chk("bready_after_aw_w", 64'({exp_write, aw_n, w_n, b_n}), 64'({1'b1, 8'd1, 8'd1, 8'd0}));
                if (rready)
                    chk("rready_after_ar", 64'({exp_write, ar_n, r_n}), 64'({1'b0, 8'd1, 8'd0}));
                if (rsp_valid) begin
                    chk("beats_at_rsp", 64'({aw_n, w_n, ar_n, b_n, r_n}),
                        exp_write ? 64'({8'd1, 8'd1, 8'd0, 8'd1, 8'd0}) : 64'({8'd0, 8'd0, 8'd1, 8'd0, 8'd1}));
                    chk("rsp_fields", 64'({rsp_write, rsp_rdata, rsp_resp, rsp_id, rsp_id_err}),
                        64'({exp_write, exp_rdata, exp_resp, exp_id, exp_err}));
                    if (lit_en)
                        chk("rsp_literal", 64'({rsp_write, rsp_rdata, rsp_resp, rsp_id, rsp_id_err}),
                            64'({lit_write, lit_rdata, lit_resp, lit_id, lit_err}));
                end
                just_acc = cmd_valid && cmd_ready;
                if (cmd_valid && cmd_ready) begin
                    busy = 1;
                    aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
                end
                if (awvalid && awready) aw_n++;
                if (wvalid && wready)   w_n++;
                if (arvalid && arready) ar_n++;
                if (bvalid && bready)   b_n++;
                if (rvalid && rready)   r_n++;
                if (rsp_valid && rsp_ready) busy = 0;
                p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
                p_wv = wvalid;   p_wr = wready;   p_wdata = wdata;
                p_arv = arvalid; p_arr = arready; p_araddr = araddr; p_arid = arid;
                p_br = bready;   p_bv = bvalid;
                p_rr = rready;   p_rv = rvalid;
            end
        end
    end

    // One command plus the slave side of its AXI transaction. Readies rise
    // a fixed number of cycles after the command is offered (possibly before
    // the matching valid); the response beat follows resp_d cycles after the
    // last request handshake; rsp_ready is withheld rr_d cycles.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] id, input int aw_d, input int w_d, input int ar_d,
                           input int resp_d, input int rr_d, input logic [1:0] resp,
                           input logic [3:0] sid, input logic [31:0] sdata);
        int t, bc, rc, rw;
        bit aw_done, w_done, a_done, b_done, r_done;
        bit cmd_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs, rsp_seen;
        exp_write = wr;
        exp_addr  = addr;
        exp_wdata = wd;
        exp_cid   = id;
        exp_rdata = wr ? 32'd0 : sdata;
        exp_resp  = resp;
        exp_id    = wr ? 4'd0 : sid;
        exp_err   = !wr && (sid != id);
        t = 0; bc = 0; rc = 0; rw = 0;
        aw_done = 0; w_done = 0; a_done = 0; b_done = 0; r_done = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_id = id;
        awready = (aw_d == 0); wready = (w_d == 0); arready = (ar_d == 0);
        bvalid = 1'b0; rvalid = 1'b0; rsp_ready = 1'b0;
        bresp = 2'($urandom); rresp = 2'($urandom); rid = 4'($urandom); rdata = $urandom;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            cmd_hs   = cmd_valid && cmd_ready;
            aw_hs    = awvalid && awready;
            w_hs     = wvalid && wready;
            ar_hs    = arvalid && arready;
            b_hs     = bvalid && bready;
            r_hs     = rvalid && rready;
            rsp_hs   = rsp_valid && rsp_ready;
            rsp_seen = rsp_valid;
            @(posedge clk);
            #1;
            t++;
            if (cmd_hs) begin
                cmd_valid = 1'b0;
                cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_id = 4'($urandom);
            end
            if (rsp_hs) begin
                rsp_ready = 1'b0;
                return;
            end
            awready = (t >= aw_d); wready = (t >= w_d); arready = (t >= ar_d);
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            if (ar_hs) a_done = 1;
            if (b_hs) begin
                bvalid = 1'b0; b_done = 1;
            end else if (wr && aw_done && w_done && !b_done && !bvalid) begin
                if (bc >= resp_d) begin bvalid = 1'b1; bresp = resp; end
                else bc++;
            end
            if (!bvalid) bresp = 2'($urandom);
            if (r_hs) begin
                rvalid = 1'b0; r_done = 1;
            end else if (!wr && a_done && !r_done && !rvalid) begin
                if (rc >= resp_d) begin rvalid = 1'b1; rid = sid; rdata = sdata; rresp = resp; end
                else rc++;
            end
            if (!rvalid) begin rid = 4'($urandom); rdata = $urandom; rresp = 2'($urandom); end
            if (rsp_seen) begin
                rw++;
                rsp_ready = (rw > rr_d);
            end
        end
        $display("FAIL txn_timeout: actual=no response required=response within 300 cycles at %0t", $time);
        $fatal(1, "transaction timed out");
    endtask

    task automatic set_lit(input bit w, input logic [31:0] d, input logic [1:0] r,
                           input logic [3:0] i, input bit e);
        lit_en = 1'b1; lit_write = w; lit_rdata = d; lit_resp = r; lit_id = i; lit_err = e;
    endtask

    logic        r_wr;
    logic [3:0]  r_id, r_sid;
    bit          accepted;

    initial begin
        areset = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_id = 0;
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;

        // basic write, B three cycles after the request beats
        set_lit(1, 32'h0, 2'd0, 4'h0, 0);
        run_txn(1, 32'h10, 32'hDEADBEEF, 4'h0, 0, 0, 0, 3, 0, 2'd0, 4'h0, 32'h0);
        // wready four cycles ahead of awready
        set_lit(1, 32'h0, 2'd1, 4'h0, 0);
        run_txn(1, 32'h44, 32'hCAFEF00D, 4'h9, 5, 1, 0, 1, 0, 2'd1, 4'h0, 32'h0);
        // read with matching ID
        set_lit(0, 32'h12345678, 2'd0, 4'h5, 0);
        run_txn(0, 32'h24, 32'h0, 4'h5, 0, 0, 0, 2, 0, 2'd0, 4'h5, 32'h12345678);
        // read with mismatching ID and SLVERR
        set_lit(0, 32'hA5A5_0F0F, 2'd2, 4'h6, 1);
        run_txn(0, 32'h28, 32'h0, 4'h3, 0, 0, 2, 0, 1, 2'd2, 4'h6, 32'hA5A5_0F0F);
        // response held off ten cycles, then a back-to-back command
        set_lit(1, 32'h0, 2'd3, 4'h0, 0);
        run_txn(1, 32'h80, 32'h0BAD_F00D, 4'h1, 0, 0, 0, 0, 10, 2'd3, 4'h0, 32'h0);
        set_lit(0, 32'h0000_1234, 2'd1, 4'hC, 0);
        run_txn(0, 32'h84, 32'h0, 4'hC, 0, 0, 0, 0, 0, 2'd1, 4'hC, 32'h0000_1234);

        // reset while arvalid waits for arready
        lit_en = 1'b0;
        exp_write = 0; exp_addr = 32'h30; exp_cid = 4'h7; exp_wdata = 0;
        exp_rdata = 0; exp_resp = 0; exp_id = 0; exp_err = 0;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30; cmd_id = 4'h7;
        arready = 0; awready = 0; wready = 0;
        accepted = 0;
        for (int k = 0; k < 20 && !accepted; k++) begin
            @(negedge clk);
            accepted = cmd_ready;
            @(posedge clk);
            #1;
            if (accepted) cmd_valid = 0;
        end
        if (!accepted) begin
            $display("FAIL reset_setup: actual=no accept required=accept within 20 cycles");
            $fatal(1, "command not accepted");
        end
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        areset = 1'b1;
        @(posedge clk);
        #1 areset = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        set_lit(0, 32'h7777_0001, 2'd0, 4'h7, 0);
        run_txn(0, 32'h30, 32'h0, 4'h7, 1, 0, 1, 1, 0, 2'd0, 4'h7, 32'h7777_0001);

        // randomized traffic
        lit_en = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r_wr  = 1'($urandom);
            r_id  = 4'($urandom);
            r_sid = ($urandom_range(1) == 1) ? r_id : 4'($urandom);
            run_txn(r_wr, $urandom, $urandom, r_id, int'($urandom_range(5)), int'($urandom_range(5)),
                    int'($urandom_range(5)), int'($urandom_range(4)), int'($urandom_range(3)),
                    2'($urandom), r_sid, $urandom);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/array_alu_axi4_master.md
Name: array_alu_axi4_master

Overview:
- Single-outstanding AXI4 initiator driving the same AW/W/B/AR/R signal subset that the array_alu slave port exposes.
- Used in integration benches and SoC glue to let a simple command/response source issue register and array accesses toward array_alu over AXI4.
- Converts one command into one AXI4 write (AW+W+B) or read (AR+R).
- Returns the slave's response with ID checking.

Parameters:
ADDR_W, 32, width of awaddr/araddr/cmd_addr
DATA_W, 32, width of wdata/rdata/cmd_wdata/rsp_rdata
ID_W, 4, width of arid/rid/cmd_id/rsp_id

Ports:
clk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data (ignored for reads)
cmd_id  in  ID_W  read ID driven on arid (ignored for writes)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  AXI response code
rsp_id  out  ID_W  ID of completed read (0 for writes)
rsp_id_err  out  1  rid differed from issued arid
awvalid  out  1  AXI write address valid
awready  in  1  AXI write address ready
awaddr  out  ADDR_W  AXI write address
wvalid  out  1  AXI write data valid
wready  in  1  AXI write data ready
wdata  out  DATA_W  AXI write data
bvalid  in  1  AXI write response valid
bresp  in  2  AXI write response
bready  out  1  AXI write response ready
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
arid  out  ID_W  AXI read ID
araddr  out  ADDR_W  AXI read address
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready
rid  in  ID_W  AXI read ID
rdata  in  DATA_W  AXI read data
rresp  in  2  AXI read response

Behaviour:
- Reset (areset=1, async): state=IDLE; every output 0, including cmd_ready, all valids/readies, addr/data/id regs and rsp_* fields. Deassertion is sampled at the next rising clk.
- State machine: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready=1; all other handshake outputs 0.
  - On cmd_valid, capture addr/wdata/id/write.
  - Write: next state WR_REQ, with awvalid=1 and wvalid=1 the following cycle.
  - Read: next state RD_REQ, with arvalid=1 the following cycle.
  - Command-to-valid latency is 1 cycle.
- WR_REQ:
  - AW and W channels are independent.
  - awvalid drops the cycle after awvalid&awready; wvalid drops the cycle after wvalid&wready.
  - Each sets a done flag; the handshakes may occur in the same cycle or in either order.
  - Once both are done, go to WR_RESP; bready=1 in that state.
  - awaddr/wdata are stable while the corresponding valid is high. Valid never drops before its handshake.
- WR_RESP: on bvalid&bready, latch rsp_resp=bresp, rsp_write=1, rsp_rdata=0, rsp_id=0, rsp_id_err=0; bready drops; go to RSP.
- RD_REQ: arvalid held with stable araddr/arid until arready; go to RD_RESP; rready=1 in that state.
- RD_RESP: on rvalid&rready, latch rsp_rdata=rdata, rsp_resp=rresp, rsp_id=rid, rsp_id_err=(rid!=issued arid), rsp_write=0; go to RSP.
- RSP: rsp_valid=1 with all rsp_* fields stable until rsp_ready; then go to IDLE. Back-to-back command acceptance is possible in the cycle after the rsp handshake.
- Only one transaction is outstanding; cmd_ready=0 outside IDLE.
- rsp_resp is passed through unmodified (OKAY/EXOKAY/SLVERR/DECERR). rsp_id_err does not alter rsp_resp.
- Reset mid-transaction: all valids/readies drop asynchronously, state returns to IDLE, and the pending transaction is discarded with no response.
- Ready signals asserted before valid (awready/wready/arready high in IDLE) cause no handshake, because valids are 0.

Test Plan:
- Write cmd addr=0x10, wdata=0xDEADBEEF; awready=wready=1, bvalid after 3 cycles with bresp=0 -> awaddr=0x10/wdata=0xDEADBEEF valid 1 cycle after cmd; then rsp_valid, rsp_write=1, rsp_resp=0.
- Write with wready asserted 4 cycles before awready -> wvalid drops first, awvalid held until its handshake, exactly one AW and one W beat, bready rises only after both handshakes.
- Read cmd addr=0x24, id=5; slave returns rid=5, rdata=0x12345678, rresp=0 -> rsp_rdata=0x12345678, rsp_id=5, rsp_id_err=0.
- Read id=3, slave returns rid=6, rresp=2 -> rsp_resp=2, rsp_id=6, rsp_id_err=1.
- rsp_ready held low 10 cycles -> rsp_* stable, cmd_ready=0 throughout; a new cmd is accepted the cycle after rsp_ready rises.
- areset pulsed while arvalid=1 awaiting arready -> arvalid=0 immediately, no rsp_valid, next read completes normally.
